// File: rtl/multicycle_control.sv
// Multi-cycle sequencing control for the 16-bit SCRISC core: FETCH/DECODE/EXEC/MEM/WB
// with req/ready memory handshakes, a bounded wait counter and a sticky FAULT state.
module multicycle_control #(
    parameter int unsigned OPW     = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           cond_true,
    input  logic           imem_ready,
    input  logic           dmem_ready,
    output logic           imem_req,
    output logic           dmem_req,
    output logic           ir_write,
    output logic           pc_inc,
    output logic           pc_load,
    output logic [1:0]     ALUOp,
    output logic [2:0]     ALUB,
    output logic [2:0]     ImmOp,
    output logic           ALUSrc,
    output logic           Branch,
    output logic           Jump,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           RegWrite,
    output logic           retire,
    output logic           fault,
    output logic [2:0]     state
);
    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    state_t          cur;
    logic [4:0]      op;
    logic [CW-1:0]   wait_cnt;
    logic            is_r, is_jmp, is_ld, is_st, is_br, direct;
    logic            rsvd, timed_out, alu_drive;

    // Instruction class decode from the registered opcode only
    always_comb begin
        is_r   = (op == 5'b11111);
        is_jmp = (op == 5'b00000) || (op[4:2] == 3'b010);
        is_ld  = (op[4:2] == 3'b001);
        is_st  = (op[4:2] == 3'b110);
        is_br  = (op[4:3] == 2'b10);
        direct = (op[4:2] == 3'b000);
    end

    assign rsvd      = ((opcode >> 5) != '0);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));
    assign alu_drive = (cur == S_EXEC) || (cur == S_MEM);
    assign state     = cur;

    // Counter clears on any cycle that does not keep waiting, so every FETCH/MEM entry starts at 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur      <= S_RST;
            op       <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (cur)
                S_RST: cur <= S_FETCH;
                S_FETCH: begin
                    if (imem_ready)     cur <= S_DECODE;
                    else if (timed_out) cur <= S_FAULT;
                    else                wait_cnt <= wait_cnt + CW'(1);
                end
                S_DECODE: begin
                    op  <= opcode[4:0];
                    cur <= rsvd ? S_FAULT : S_EXEC;
                end
                S_EXEC: begin
                    if (is_br)                cur <= S_FETCH;
                    else if (is_ld || is_st)  cur <= S_MEM;
                    else                      cur <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready)     cur <= is_ld ? S_WB : S_FETCH;
                    else if (timed_out) cur <= S_FAULT;
                    else                wait_cnt <= wait_cnt + CW'(1);
                end
                S_WB:    cur <= S_FETCH;
                S_FAULT: cur <= S_FAULT;
                default: cur <= S_FAULT;
            endcase
        end
    end

    // State-qualified controls; only handshake completion and cond_true are sampled live
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_write = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ALUOp    = 2'b00;
        ALUB     = 3'b000;
        ImmOp    = 3'b000;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        retire   = 1'b0;
        fault    = (cur == S_FAULT);

        if (alu_drive) begin
            ALUOp  = {is_br | is_r, is_ld | is_r};
            ALUB   = {op[3], op[1], op[0]};
            ImmOp  = {direct & op[0], is_jmp | is_br, direct};
            ALUSrc = ~is_r;
        end

        case (cur)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_inc   = imem_ready;
            end
            S_EXEC: begin
                Branch  = is_br;
                Jump    = is_jmp;
                pc_load = is_jmp | (is_br & cond_true);
                retire  = is_br;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemRead  = is_ld;
                MemWrite = is_st;
                retire   = is_st & dmem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = is_ld;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing control unit for the 16-bit SCRISC core. It walks every instruction through FETCH, DECODE, EXEC, then optionally MEM and WB. Instruction and data memory accesses use a req/ready handshake, and a bounded wait counter faults the core if memory stops responding. All per-instruction control fields come from a registered opcode and are qualified by state, so the datapath sees one-cycle register-write and PC-update strobes instead of level signals.

## Interface

- OPW, 5: opcode width. Must be ≥5. Bits above [4:0] are reserved and must be zero.
- TIMEOUT, 16: maximum wait cycles on a memory handshake before FAULT. 0 disables the timeout.
- clk  in  1  clock; everything updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  OPW  instruction opcode field from the IR; sampled in DECODE
- cond_true  in  1  branch condition from the ALU flags; sampled in EXEC
- imem_ready  in  1  instruction memory handshake complete
- dmem_ready  in  1  data memory handshake complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- ir_write, pc_inc  out  1  IR load and PC+2, pulsed together on fetch completion
- pc_load  out  1  PC load from branch/jump target
- ALUOp  out  2  ALU operation class
- ALUB  out  3  {btype, binv, bunsig}
- ImmOp  out  3  {sll7, sll1, imm7/9}
- ALUSrc, Branch, Jump, MemRead, MemWrite, MemtoReg, RegWrite  out  1  datapath controls
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- fault  out  1  sticky timeout or illegal-opcode flag
- state  out  3  current state: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7

## Operation

Opcode classes, decoded from the registered opcode `op`:
- R: op=11111
- JMP: op=00000 or 010xx
- LD: 001xx
- ST: 110xx
- BR: 10xxx
- IMM: all other codes

Field rules:
- ALUSrc=~R
- ALUOp={BR|R, LD|R}
- ALUB={op[3], op[1], op[0]}
- ImmOp={direct&op[0], JMP|BR, direct}, where direct = (op[4:2]==000)

State transitions:
- RST → FETCH unconditionally. All outputs are 0 in RST.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=pc_inc=1 for that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Register opcode[4:0] into `op`.
  - If any opcode bit above [4] is set, go to FAULT.
  - Otherwise go to EXEC. No datapath strobes.
- EXEC:
  - ALUOp, ALUB, ImmOp and ALUSrc are driven.
  - Branch=BR and Jump=JMP.
  - pc_load = JMP | (BR & cond_true).
  - Next state: LD/ST → MEM; R/IMM/JMP → WB; BR → FETCH with retire=1.
- MEM:
  - dmem_req=1, with MemRead=LD and MemWrite=ST.
  - The ALU fields stay driven so the address remains stable.
  - On dmem_ready: LD → WB; ST → FETCH with retire=1.
- WB:
  - RegWrite=1 and MemtoReg=LD, for one cycle.
  - JMP writes the link register.
  - retire=1, then go to FETCH.
- FAULT:
  - fault=1; every other output is 0.
  - FAULT is left only by reset.

Output gating:
- Control fields are 0 in any state where they are not listed above.
- Decode outputs are Moore outputs: a function of state and `op` only, never of the live opcode input.

Wait counter (width $clog2(TIMEOUT+1)):
- Cleared on every entry to FETCH or MEM.
- Increments each cycle the relevant ready is low.
- When the counter equals TIMEOUT-1 and ready is still low, the next state is FAULT. This allows TIMEOUT not-ready cycles.
- If ready is high in that same cycle, the handshake completes normally.

## Timing

- Minimum cycles per instruction, with ready high on the first request cycle:
  - BR: 3
  - R, IMM, JMP, ST: 4
  - LD: 5
- Each wait cycle adds one cycle.
- Handshake rules:
  - req stays high until the cycle in which ready is sampled high.
  - req drops in the following cycle because the state advances.
  - ready is ignored while the matching req is low.
- Reset:
  - rst_n=0 at any edge, including mid-MEM, forces RST next cycle.
  - Strobes and the counter clear on that edge.
  - No retire or RegWrite is emitted for the aborted instruction.
- fault rises in the first FAULT cycle. All other outputs are 0 from that cycle.

## Test plan

- R-type: reset, opcode=11111, imem_ready=1 → state 1,2,3,5,1; RegWrite=1 and retire=1 in the WB cycle only; ALUOp=11, ALUSrc=0 in EXEC.
- Load with wait: opcode=00101, dmem_ready low 3 cycles then high → dmem_req high 4 cycles with MemRead=1; WB has MemtoReg=1, RegWrite=1; 8 cycles from FETCH to retire.
- Store: opcode=11000 → MEM has MemWrite=1; RegWrite never asserted; retire on the dmem_ready cycle; next state FETCH.
- Branch: opcode=10001 → ImmOp=010, ALUOp=10; pc_load=0 with cond_true=0 and pc_load=1 with cond_true=1, both in EXEC; 3-cycle retire.
- Timeout: TIMEOUT=16 with imem_ready held 0 → FAULT entered after exactly 16 FETCH cycles and held. Ready asserted on the 16th cycle → normal DECODE instead.
- Reset mid-MEM, plus OPW=6 with opcode=100000 → the reset case returns to RST with no retire; the OPW=6 case goes from DECODE to FAULT.
